down_timer: RTL and testbench
=============================

// Module: down_timer
// PURPOSE
//   Loadable down-counter/timer; the count-down counterpart to our free-running up counter.
//   Counts a loaded value down to terminal count (TC) and emits a one-cycle tc pulse.
//   One-shot mode stops at zero. Periodic mode auto-reloads, producing a divided-clock tick.
//   Sits beside the up counter as the timing source for delays and rate dividers.
// PARAMETERS
//   WIDTH   8   counter/load width in bits (>=2)
// PORTS
//   clk          in   1      system clock, all state updates on posedge
//   rst_n        in   1      asynchronous, active-low reset
//   load         in   1      capture load_value into count and reload register
//   load_value   in   WIDTH  initial/reload value N (period = N enabled cycles)
//   enable       in   1      count-down qualifier; low = hold
//   auto_reload  in   1      1 = periodic, 0 = one-shot; sampled on each terminal decrement
//   stop         in   1      abort: return to IDLE, count held
//   count        out  WIDTH  current count (registered)
//   busy         out  1      1 while in RUN
//   tc           out  1      registered one-cycle pulse on terminal decrement
// BEHAVIOUR
//   Reset (rst_n=0, async): count=0, reload_reg=0, busy=0, tc=0, state=IDLE; held until release.
//   States: IDLE (busy=0), RUN (busy=1). Default tc=0 every cycle unless set below.
//   Priority per cycle: stop > load > enable-decrement > hold.
//   stop=1: state->IDLE, count unchanged, tc=0 (also overrides a same-cycle load).
//   load=1 (any state): reload_reg<=load_value, count<=load_value;
//     load_value!=0 -> RUN next cycle; load_value==0 -> IDLE, no tc.
//     Load in same cycle as a terminal decrement: load wins, no tc.
//   RUN, enable=1, count>1: count<=count-1.
//   RUN, enable=1, count==1 (terminal decrement): tc<=1 next cycle, and
//     auto_reload=1 -> count<=reload_reg, stay RUN;
//     auto_reload=0 -> count<=0, state->IDLE.
//   RUN, enable=0: count and state hold; no tc.
//   IDLE: enable ignored; count holds.
//   Latency: load->count visible 1 cycle; first tc exactly N enabled cycles after load cycle.
//   Boundary conditions:
//     - Periodic with N=1: tc high on every enabled cycle; count stays 1.
//     - N = 2**WIDTH-1 is legal; count never wraps below 0; no underflow path.
//   Mid-operation reset: immediate clear regardless of state.
//   count never leaves the range 0..reload_reg.
// STRUCTURE
//   Package down_timer_pkg: state encoding localparams ST_IDLE=1'b0, ST_RUN=1'b1;
//     mode constants MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1.
//   Single module: the FSM and datapath are small, and no sub-module is warranted.
//   All outputs are driven directly from flops; no combinational paths from inputs to outputs.
// TESTING
//   1. Reset mid-RUN (count=5) -> count=0, busy=0, tc=0 during the same cycle as rst_n falling.
//   2. WIDTH=8, load 3, auto_reload=0, enable=1 -> count 3,2,1,0; tc=1 with count=0; busy=0 after.
//   3. load 4, auto_reload=1, enable=1 for 12 cycles -> tc on cycles 4, 8, 12; count 4,3,2,1,4,...
//   4. load 5, enable toggles 1,0,1,0,... -> count decrements only on enabled cycles; tc after 5th enable.
//   5. load 0 -> busy stays 0, count=0, no tc; load 1 periodic -> tc every enabled cycle.
//   6. Priority checks:
//      - stop and load together -> IDLE, count unchanged.
//      - load 9 at terminal count -> count=9, no tc.

Source files
------------

// File: rtl/down_timer_pkg.sv
// Shared state and mode encodings for the loadable down-counter/timer.
package down_timer_pkg;
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/down_timer_if.sv
// Control/status bundle between a timer user (master) and the down_timer (slave).
interface down_timer_if #(
    parameter int WIDTH = 8
);
    import down_timer_pkg::*;

    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             enable;
    logic             auto_reload;
    logic             stop;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;

    modport master (
        output load, load_value, enable, auto_reload, stop,
        input  count, busy, tc
    );

    modport slave (
        input  load, load_value, enable, auto_reload, stop,
        output count, busy, tc
    );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counter: one-shot or periodic, with a registered one-cycle tc pulse.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    down_timer_if.slave tif
);
    state_t           state_q, state_n;
    logic [WIDTH-1:0] count_q, count_n;
    logic [WIDTH-1:0] reload_q, reload_n;
    logic             tc_q, tc_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_n;
            count_q  <= count_n;
            reload_q <= reload_n;
            tc_q     <= tc_n;
        end
    end

    // stop beats load beats enabled decrement; everything else holds.
    always_comb begin
        state_n  = state_q;
        count_n  = count_q;
        reload_n = reload_q;
        tc_n     = 1'b0;
        if (tif.stop) begin
            state_n = ST_IDLE;
        end else if (tif.load) begin
            reload_n = tif.load_value;
            count_n  = tif.load_value;
            state_n  = (tif.load_value != '0) ? ST_RUN : ST_IDLE;
        end else if (state_q == ST_RUN && tif.enable) begin
            if (count_q == WIDTH'(1)) begin
                tc_n = 1'b1;
                if (tif.auto_reload == MODE_PERIODIC) begin
                    count_n = reload_q;
                end else begin
                    count_n = '0;
                    state_n = ST_IDLE;
                end
            end else if (count_q != '0) begin
                // RUN is only entered with a nonzero count, so this never underflows.
                count_n = count_q - WIDTH'(1);
            end
        end
    end

    assign tif.count = count_q;
    assign tif.busy  = (state_q == ST_RUN);
    assign tif.tc    = tc_q;
endmodule

// File: tb/tb_down_timer.sv
// Directed scenarios plus randomized traffic checked against a phase-based timer model.
module tb_down_timer;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    down_timer_if #(.WIDTH(WIDTH)) tif ();

    down_timer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tif   (tif)
    );

    always #5 clk = ~clk;

    // Model: period N, enabled decrements k since the last (re)load, value held while idle.
    int m_n, m_k, m_hold;
    bit m_run, m_tc;

    function automatic int exp_count();
        return m_run ? (m_n - m_k) : m_hold;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_k = 0; m_hold = 0; m_run = 0; m_tc = 0;
    endtask

    task automatic model_update(input bit ld, input int lv, input bit en, input bit ar, input bit st);
        m_tc = 0;
        if (st) begin
            if (m_run) m_hold = m_n - m_k;
            m_run = 0;
        end else if (ld) begin
            m_n = lv; m_k = 0; m_hold = lv; m_run = (lv != 0);
        end else if (m_run && en) begin
            m_k++;
            if (m_k == m_n) begin
                m_tc = 1;
                if (ar) m_k = 0;
                else begin m_run = 0; m_hold = 0; end
            end
        end
    endtask

    task automatic step(input bit ld, input int lv, input bit en, input bit ar, input bit st,
                        input string tag);
        tif.load = ld; tif.load_value = WIDTH'(lv); tif.enable = en;
        tif.auto_reload = ar; tif.stop = st;
        @(posedge clk);
        model_update(ld, lv, en, ar, st);
        #1;
        chk({tag, "_count"}, 32'(tif.count), 32'(exp_count()));
        chk({tag, "_busy"},  32'(tif.busy),  32'(m_run));
        chk({tag, "_tc"},    32'(tif.tc),    32'(m_tc));
    endtask

    int tcs;

    initial begin
        tif.load = 0; tif.load_value = '0; tif.enable = 0; tif.auto_reload = 0; tif.stop = 0;
        model_reset();
        #12;
        chk("rst_count", 32'(tif.count), 0);
        chk("rst_busy",  32'(tif.busy),  0);
        chk("rst_tc",    32'(tif.tc),    0);
        rst_n = 1'b1;

        // Async reset while running at count 5
        step(1, 9, 1, 0, 0, "t1_ld");
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, "t1_run");
        chk("t1_pre", 32'(tif.count), 5);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("t1_rst_count", 32'(tif.count), 0);
        chk("t1_rst_busy",  32'(tif.busy),  0);
        chk("t1_rst_tc",    32'(tif.tc),    0);
        #1 rst_n = 1'b1;

        // One-shot of 3
        step(1, 3, 1, 0, 0, "t2_ld");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, "t2_run");
        chk("t2_end_tc", 32'(tif.tc), 1);
        chk("t2_end_busy", 32'(tif.busy), 0);
        step(0, 0, 1, 0, 0, "t2_idle");

        // Periodic 4 over 12 enabled cycles -> 3 ticks
        step(1, 4, 1, 1, 0, "t3_ld");
        tcs = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 1, 1, 0, "t3_run");
            tcs += int'(tif.tc);
        end
        chk("t3_ticks", 32'(tcs), 3);

        // Load 5 with enable toggling
        step(1, 5, 1, 0, 0, "t4_ld");
        for (int i = 0; i < 10; i++) step(0, 0, (i % 2 == 0), 0, 0, "t4_run");

        // Load 0, then periodic N=1
        step(1, 0, 1, 1, 0, "t5_ld0");
        step(0, 0, 1, 1, 0, "t5_idle");
        step(1, 1, 1, 1, 0, "t5_ld1");
        tcs = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 1, 0, "t5_run");
            tcs += int'(tif.tc);
        end
        chk("t5_ticks", 32'(tcs), 5);

        // stop+load together; load at terminal count
        step(1, 7, 1, 0, 0, "t6_ld");
        step(0, 0, 1, 0, 0, "t6_run");
        step(0, 0, 1, 0, 0, "t6_run");
        step(1, 3, 1, 0, 1, "t6_stopld");
        chk("t6_stop_count", 32'(tif.count), 5);
        step(1, 2, 1, 0, 0, "t6_ld2");
        step(0, 0, 1, 0, 0, "t6_run2");
        step(1, 9, 1, 1, 0, "t6_ldtc");
        chk("t6_ldtc_count", 32'(tif.count), 9);
        chk("t6_ldtc_tc", 32'(tif.tc), 0);

        // Max period is legal
        step(1, 255, 1, 0, 0, "t7_ld");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, "t7_run");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int  lv;
            int  sel;
            sel = int'($urandom_range(0, 9));
            lv  = (sel == 0) ? 0 : (sel == 1) ? 1 : (sel == 2) ? 255
                : int'($urandom_range(2, 12));
            step(($urandom_range(0, 15) == 0), lv, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
